// File: rtl/digit_gen_pkg.sv
// rtl/digit_gen_pkg.sv - shared constants for the digit pattern generator
// Purpose: coordinate width, seven-segment bit positions and the digit masks.
// Ports: none (package).
package digit_gen_pkg;

    localparam int COORD_W = 11;

    // Mask bit positions, mask written as abcdefg with a in the MSB
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_MASK_0 = 7'b1111110;
    localparam logic [6:0] SEG_MASK_1 = 7'b0110000;
    localparam logic [6:0] SEG_MASK_2 = 7'b1101101;
    localparam logic [6:0] SEG_MASK_3 = 7'b1111001;
    localparam logic [6:0] SEG_MASK_4 = 7'b0110011;
    localparam logic [6:0] SEG_MASK_5 = 7'b1011011;
    localparam logic [6:0] SEG_MASK_6 = 7'b1011111;
    localparam logic [6:0] SEG_MASK_7 = 7'b1110000;
    localparam logic [6:0] SEG_MASK_8 = 7'b1111111;
    localparam logic [6:0] SEG_MASK_9 = 7'b1111011;

endpackage

// File: rtl/digit_seg_rom.sv
// rtl/digit_seg_rom.sv - digit to seven-segment mask lookup, captured at frame start
// Purpose: holds the segment mask of the active digit for a whole frame.
// Ports: clk, rst (async, active-high); load_i captures digit_i's mask;
//        mask_o is the registered abcdefg mask (all zero for digits above 9).
module digit_seg_rom
    import digit_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] digit_i,
    output logic [6:0] mask_o
);

    logic [6:0] mask_q;
    logic [6:0] mask_d;

    always_comb begin
        mask_d = 7'b0000000;
        case (digit_i)
            4'd0:    mask_d = SEG_MASK_0;
            4'd1:    mask_d = SEG_MASK_1;
            4'd2:    mask_d = SEG_MASK_2;
            4'd3:    mask_d = SEG_MASK_3;
            4'd4:    mask_d = SEG_MASK_4;
            4'd5:    mask_d = SEG_MASK_5;
            4'd6:    mask_d = SEG_MASK_6;
            4'd7:    mask_d = SEG_MASK_7;
            4'd8:    mask_d = SEG_MASK_8;
            4'd9:    mask_d = SEG_MASK_9;
            default: mask_d = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 7'b0000000;
        end else if (load_i) begin
            mask_q <= mask_d;
        end
    end

    assign mask_o = mask_q;

endmodule

// File: rtl/digit_pattern_gen.sv
// rtl/digit_pattern_gen.sv - synthetic raster with a seven-segment digit glyph in a box
// Purpose: raster counters, shadow/active box configuration, frame validation and a
//          two-stage compare pipeline producing a 1-bit pixel stream (0 = ink).
// Ports: clk, rst (async, active-high); cfg_valid/cfg_digit/cfg_box_* load the shadow set;
//        frame_vs, hcount, vcount, post_Bit are the aligned pixel outputs;
//        hcount_l/r, vcount_l/r are the active box bounds; frame_cnt is the frame phase;
//        cfg_err flags a frame whose box failed validation.
// Build option: DIGIT_GEN_AUTO_INC_EN steps the digit 0..9 every four frames, ignoring cfg_digit.
module digit_pattern_gen
    import digit_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int STROKE   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    input  logic [3:0]         cfg_digit,
    input  logic [COORD_W-1:0] cfg_box_x,
    input  logic [COORD_W-1:0] cfg_box_y,
    input  logic [COORD_W-1:0] cfg_box_w,
    input  logic [COORD_W-1:0] cfg_box_h,
    output logic               frame_vs,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               post_Bit,
    output logic [COORD_W-1:0] hcount_l,
    output logic [COORD_W-1:0] hcount_r,
    output logic [COORD_W-1:0] vcount_l,
    output logic [COORD_W-1:0] vcount_r,
    output logic [2:0]         frame_cnt,
    output logic               cfg_err
);

    localparam int CW = COORD_W;
    localparam logic [CW-1:0] STK      = CW'(STROKE);
    localparam logic [CW-1:0] HALF_STK = CW'(STROKE / 2);
    localparam logic [CW-1:0] MIN_W    = CW'(3 * STROKE);
    localparam logic [CW-1:0] MIN_H    = CW'(5 * STROKE);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Raster counters
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          frame_start;

    always_comb begin
        frame_start = (h_q == '0) && (v_q == '0);
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Shadow configuration, written any time by cfg_valid
    logic [3:0]    sh_digit_q;
    logic [CW-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digit_q <= 4'd15;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_w_q     <= '0;
            sh_h_q     <= '0;
        end else if (cfg_valid) begin
            sh_digit_q <= cfg_digit;
            sh_x_q     <= cfg_box_x;
            sh_y_q     <= cfg_box_y;
            sh_w_q     <= cfg_box_w;
            sh_h_q     <= cfg_box_h;
        end
    end

    // Active box. The _d view is what the current frame uses, so the frame-start
    // pixel is compared against the newly adopted box rather than the old one.
    logic [CW-1:0] act_x_q, act_y_q, act_w_q, act_h_q;
    logic [CW-1:0] act_x_d, act_y_d, act_w_d, act_h_d;
    logic [CW:0]   sum_x, sum_y;
    logic          cfg_bad;
    logic          err_q;
    logic [1:0]    fc_q;
    logic          first_q;

    always_comb begin
        act_x_d = frame_start ? sh_x_q : act_x_q;
        act_y_d = frame_start ? sh_y_q : act_y_q;
        act_w_d = frame_start ? sh_w_q : act_w_q;
        act_h_d = frame_start ? sh_h_q : act_h_q;
        // One extra bit so an oversized box cannot wrap into a passing sum
        sum_x   = {1'b0, sh_x_q} + {1'b0, sh_w_q};
        sum_y   = {1'b0, sh_y_q} + {1'b0, sh_h_q};
        cfg_bad = (sh_w_q < MIN_W) || (sh_h_q < MIN_H) ||
                  (sum_x > {1'b0, H_ACT}) || (sum_y > {1'b0, V_ACT});
    end

    // The first frame after reset is phase 0, so only later frame starts advance the phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_x_q <= '0;
            act_y_q <= '0;
            act_w_q <= '0;
            act_h_q <= '0;
            err_q   <= 1'b0;
            fc_q    <= 2'd0;
            first_q <= 1'b1;
        end else if (frame_start) begin
            act_x_q <= sh_x_q;
            act_y_q <= sh_y_q;
            act_w_q <= sh_w_q;
            act_h_q <= sh_h_q;
            err_q   <= cfg_bad;
            first_q <= 1'b0;
            if (!first_q) begin
                fc_q <= fc_q + 2'd1;
            end
        end
    end

    // Digit selection
    logic [3:0] rom_digit;
    logic [6:0] seg_mask;

`ifdef DIGIT_GEN_AUTO_INC_EN
    logic [3:0] auto_digit_q, auto_digit_d;

    always_comb begin
        auto_digit_d = auto_digit_q;
        if (frame_start && !first_q && (fc_q == 2'd3)) begin
            auto_digit_d = (auto_digit_q == 4'd9) ? 4'd0 : auto_digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_digit_q <= 4'd0;
        end else begin
            auto_digit_q <= auto_digit_d;
        end
    end

    assign rom_digit = auto_digit_d;
`else
    assign rom_digit = sh_digit_q;
`endif

    digit_seg_rom u_seg_rom (
        .clk     (clk),
        .rst     (rst),
        .load_i  (frame_start),
        .digit_i (rom_digit),
        .mask_o  (seg_mask)
    );

    // Stage 1: per-segment range compares on the raster position
    logic [CW-1:0] xe, ye, xr, ym, yb;
    logic          in_box_d, up_d, lo_d, col_l_d, col_r_d;
    logic [6:0]    seg_d;

    always_comb begin
        xe = act_x_d + act_w_d;
        ye = act_y_d + act_h_d;
        xr = xe - STK;
        ym = act_y_d + (act_h_d >> 1) - HALF_STK;
        yb = ye - STK;
        in_box_d = (h_q < H_ACT) && (v_q < V_ACT) &&
                   (h_q >= act_x_d) && (h_q < xe) && (v_q >= act_y_d) && (v_q < ye);
        // Upper and lower halves overlap on the middle stroke rows
        up_d    = v_q < ym + STK;
        lo_d    = v_q >= ym;
        col_l_d = h_q < act_x_d + STK;
        col_r_d = h_q >= xr;
        seg_d        = '0;
        seg_d[SEG_A] = v_q < act_y_d + STK;
        seg_d[SEG_B] = col_r_d && up_d;
        seg_d[SEG_C] = col_r_d && lo_d;
        seg_d[SEG_D] = v_q >= yb;
        seg_d[SEG_E] = col_l_d && lo_d;
        seg_d[SEG_F] = col_l_d && up_d;
        seg_d[SEG_G] = (v_q >= ym) && (v_q < ym + STK);
    end

    logic [CW-1:0] s1_h_q, s1_v_q;
    logic          s1_vs_q, s1_in_q, s1_start_q;
    logic [6:0]    s1_seg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_h_q     <= '0;
            s1_v_q     <= '0;
            s1_vs_q    <= 1'b0;
            s1_in_q    <= 1'b0;
            s1_start_q <= 1'b0;
            s1_seg_q   <= '0;
        end else begin
            s1_h_q     <= h_q;
            s1_v_q     <= v_q;
            s1_vs_q    <= v_q < V_ACT;
            s1_in_q    <= in_box_d;
            s1_start_q <= frame_start;
            s1_seg_q   <= seg_d;
        end
    end

    // Stage 2: pixel decision and frame-aligned status
    logic          ink_d;
    logic          vs_q, bit_q, err_out_q;
    logic [CW-1:0] hc_q, vc_q, hl_q, hr_q, vl_q, vr_q;
    logic [2:0]    fc_out_q;

    assign ink_d = s1_in_q && !err_q && (|(s1_seg_q & seg_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q      <= 1'b0;
            bit_q     <= 1'b1;
            hc_q      <= '0;
            vc_q      <= '0;
            hl_q      <= '0;
            hr_q      <= '0;
            vl_q      <= '0;
            vr_q      <= '0;
            fc_out_q  <= 3'd0;
            err_out_q <= 1'b0;
        end else begin
            vs_q  <= s1_vs_q;
            bit_q <= !ink_d;
            hc_q  <= s1_h_q;
            vc_q  <= s1_v_q;
            if (s1_start_q) begin
                hl_q      <= act_x_q;
                hr_q      <= act_x_q + act_w_q - CW'(1);
                vl_q      <= act_y_q;
                vr_q      <= act_y_q + act_h_q - CW'(1);
                fc_out_q  <= {1'b0, fc_q};
                err_out_q <= err_q;
            end
        end
    end

    assign frame_vs  = vs_q;
    assign post_Bit  = bit_q;
    assign hcount    = hc_q;
    assign vcount    = vc_q;
    assign hcount_l  = hl_q;
    assign hcount_r  = hr_q;
    assign vcount_l  = vl_q;
    assign vcount_r  = vr_q;
    assign frame_cnt = fc_out_q;
    assign cfg_err   = err_out_q;

endmodule

// File: doc/digit_pattern_gen.md
# digit_pattern_gen

Synthetic binary-video source for the digit-recognition path. Generates a raster with frame and line counters and a frame-phase counter, plus a one-bit pixel stream containing a seven-segment glyph of a selected digit inside a programmable bounding box. Outputs drop straight onto the recognizer's pixel, count, bounds and frame inputs, so the recognition pipeline can be exercised and debugged without a camera.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line (≥ H_ACTIVE+2)
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame (≥ V_ACTIVE+2)
- STROKE, 8, glyph stroke width in pixels, both axes
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  one-cycle strobe; loads the shadow configuration
- cfg_digit  in  4  digit to draw; values 10–15 draw a blank box
- cfg_box_x, cfg_box_y  in  11  top-left corner of the box
- cfg_box_w, cfg_box_h  in  11  box width and height
- frame_vs  out  1  high while v < V_ACTIVE
- hcount, vcount  out  11  raster position of the current post_Bit
- post_Bit  out  1  pixel value: 1 = background, 0 = ink
- hcount_l, hcount_r, vcount_l, vcount_r  out  11  active box bounds (x, x+w−1, y, y+h−1)
- frame_cnt  out  3  frame phase, counts 0..3 and wraps
- cfg_err  out  1  high for a frame whose box failed validation

## Operation
- Raster counters: h runs 0..H_TOTAL−1; v increments when h wraps and runs 0..V_TOTAL−1.
- Frame start is the cycle where h=0 and v=0.
- Shadow configuration:
  - cfg_valid writes the shadow registers.
  - At frame start the shadow is copied to the active registers and frame_cnt increments modulo 4.
  - If cfg_valid coincides with frame start, the active set takes the previous shadow and the new value applies from the next frame.
- Validation at frame start:
  - Fails if box_w < 3·STROKE, box_h < 5·STROKE, box_x+box_w > H_ACTIVE, or box_y+box_h > V_ACTIVE.
  - On failure: cfg_err=1 and the whole frame is background.
- Glyph geometry, all 11-bit unsigned. Let xr = x+w−STROKE, ym = y+(h>>1)−(STROKE>>1), yb = y+h−STROKE.
  - a: rows [y, y+STROKE)
  - g: rows [ym, ym+STROKE)
  - d: rows [yb, y+h)
  - f / e: columns [x, x+STROKE), upper half / lower half
  - b / c: columns [xr, x+w), upper half / lower half
  - Upper half is rows < ym+STROKE; lower half is rows ≥ ym.
  - Horizontal segments span the full box width.
- Segment masks (abcdefg):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Other values: 0000000.
- post_Bit = 0 only when the pixel is active, inside the box, and inside an enabled segment.
- Reset values: counters, hcount and vcount = 0; frame_vs = 0; post_Bit = 1; bounds = 0; frame_cnt = 0; cfg_err = 0; shadow and active digit = 15 (blank).
- Reset mid-frame restarts the raster at h=v=0 with the outputs above.

## Timing
- Two-stage pipeline:
  - Stage 1 registers h, v and the per-segment range compares.
  - Stage 2 registers post_Bit together with the matching hcount, vcount and frame_vs.
  - Outputs are always mutually aligned. Latency from raster counter to output is 2 cycles.
- Bounds and cfg_err update in the same cycle frame_vs rises at the output, and stay constant for the entire frame.
- frame_cnt changes on the same output cycle as the frame_vs rise.
- First output cycle after reset release: hcount=0, vcount=0 two cycles later. Before that, outputs hold their reset values.

## Configuration
- DIGIT_GEN_AUTO_INC_EN
  - Defined: cfg_digit is ignored; the active digit starts at 0 and advances 0→9→0 each time frame_cnt wraps 3→0. Box configuration still comes from the shadow registers.
  - Undefined: the digit comes only from cfg_digit.

## Structure
- Package digit_gen_pkg holds:
  - the ten 7-bit segment masks
  - segment index constants (SEG_A..SEG_G)
  - the 11-bit coordinate width constant
- Sub-module digit_seg_rom maps the 4-bit digit to its 7-bit mask and returns 0 for digits above 9. It is registered at frame start only.
- Everything else (raster counters, shadow/active registers, validation, compare pipeline) lives in the top level.

## Test plan
- Digit 8, box (100,100,80,160), STROKE 8 → on line vcount=140 the two ink runs are hcount 100–107 and 172–179; line 100 is ink over 100–179.
- Digit 1, same box → every active line inside the box has ink only at 172–179; columns 100–107 are always 1.
- Digit 12 → no 0 pixels in the frame; bounds = 100/179/100/259; cfg_err=0.
- Box (600,100,80,160) (overflows H_ACTIVE) → cfg_err=1 for that frame; all post_Bit=1; the next valid cfg clears cfg_err at the following frame start.
- cfg_valid on the exact frame-start cycle with digit 7, previous shadow 3 → that frame draws 3; the next frame draws 7.
- rst asserted at v=200, then released → outputs return to reset values immediately; frame_cnt=0; the first frame_vs rise occurs 2 cycles after release. With DIGIT_GEN_AUTO_INC_EN defined, digits run 0,0,0,0,1,… across successive frames.
